// File: rtl/fetch_pkg.sv
// Shared definitions for the Thumb fetch sequencer slice.
//   THUMB_INSTR_W : width of one Thumb instruction (16)
//   PC_STEP       : sequential pc increment in bytes (2)
//   fetch_state_t : sequencer FSM states
package fetch_pkg;

  localparam int unsigned THUMB_INSTR_W = 16;
  localparam logic [31:0] PC_STEP       = 32'd2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register with next-pc selection.
//   clk, rst  : clock, asynchronous active-high reset (loads RESET_PC)
//   step      : advance the pc this cycle
//   redirect  : when stepping, take target (bit 0 cleared) instead of pc+2
//   target    : redirect address
//   pc        : current program counter
module fetch_pc
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic        redirect,
  input  logic [31:0] target,
  output logic [31:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (step) begin
      // Halfword-aligned redirect; the sequential add wraps modulo 2^32.
      if (redirect) pc <= {target[31:1], 1'b0};
      else          pc <= pc + PC_STEP;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Thumb instruction fetch sequencer: IDLE -> FETCH -> DECODE -> EXEC loop.
// Optional macro FETCH_HALT_ON_ILLEGAL_EN: an illegal instruction parks the
// sequencer in HALT with pc at the offending instruction; otherwise illegal
// instructions are skipped and halted is tied low.
//   clk, rst       : clock, asynchronous active-high reset
//   imem_req/addr  : instruction read request (FETCH only), address = pc
//   imem_ack/data  : read completion and returned instruction
//   instr          : instruction register to the decoder
//   instr_valid    : one-cycle strobe in DECODE
//   illegal        : decoder illegal flag, used in EXEC
//   exec_done      : datapath finished the current instruction
//   branch_taken   : redirect request, qualified by exec_done
//   branch_target  : redirect address
//   pc             : address of the instruction held in instr
//   halted         : high while in HALT
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [THUMB_INSTR_W-1:0] imem_data,
  output logic [THUMB_INSTR_W-1:0] instr,
  output logic                     instr_valid,
  input  logic                     illegal,
  input  logic                     exec_done,
  input  logic                     branch_taken,
  input  logic [31:0]              branch_target,
  output logic [31:0]              pc,
  output logic                     halted
);

  fetch_state_t state;
  logic         exec_fire;
  logic         pc_step;
  logic         pc_redirect;

  // EXEC completes on either exec_done or illegal; illegal wins over a branch.
  always_comb begin
    exec_fire   = (state == EXEC) && (exec_done || illegal);
`ifdef FETCH_HALT_ON_ILLEGAL_EN
    pc_step     = exec_fire && !illegal;
`else
    pc_step     = exec_fire;
`endif
    pc_redirect = exec_done && branch_taken && !illegal;
  end

  fetch_pc #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .step     (pc_step),
    .redirect (pc_redirect),
    .target   (branch_target),
    .pc       (pc)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      instr       <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
`ifdef FETCH_HALT_ON_ILLEGAL_EN
      halted      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_data;
            state       <= DECODE;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        DECODE: begin
          state       <= EXEC;
          instr_valid <= 1'b0;
        end
        EXEC: begin
`ifdef FETCH_HALT_ON_ILLEGAL_EN
          if (illegal) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (exec_done) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
`else
          if (exec_done || illegal) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
`endif
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef FETCH_HALT_ON_ILLEGAL_EN
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic        illegal;
  logic        exec_done;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic        halted;

  int unsigned checks;
  int unsigned errors;
  logic [31:0] exp_pc;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  fetch_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_data     (imem_data),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .illegal       (illegal),
    .exec_done     (exec_done),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0 ||
        instr !== 16'h0 || pc !== RST_PC) begin
      errors++;
      $display("FAIL reset_state req=%b vld=%b halt=%b instr=%h pc=%h required 0 0 0 0000 %h",
               imem_req, instr_valid, halted, instr, pc, RST_PC);
    end
    cyc();
    cyc();
    rst = 1'b0;
    exp_pc = RST_PC;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req req=%b required 0", imem_req);
    end
    cyc();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
      errors++;
      $display("FAIL idle_one_cycle req=%b addr=%h required 1 %h", imem_req, imem_addr, exp_pc);
    end
  endtask

  // One instruction through fetch/decode/exec; the model tracks the pc from
  // the architectural rules only.
  task automatic do_instr(input logic [15:0] d, input int unsigned ws, input int unsigned es,
                          input logic done, input logic br, input logic [31:0] tgt,
                          input logic ill);
    int unsigned n;
    logic [15:0] prev;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_timeout req=%b required 1", imem_req);
      return;
    end
    checks++;
    if (imem_addr !== exp_pc) begin
      errors++;
      $display("FAIL fetch_addr addr=%h required %h", imem_addr, exp_pc);
    end
    prev = instr;
    for (int unsigned i = 0; i < ws; i++) begin
      imem_data = 16'($urandom);
      cyc();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr !== prev || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL fetch_hold req=%b addr=%h instr=%h vld=%b required 1 %h %h 0",
                 imem_req, imem_addr, instr, instr_valid, exp_pc, prev);
      end
    end
    imem_ack  = 1'b1;
    imem_data = d;
    cyc();
    imem_ack  = 1'b0;
    imem_data = 16'($urandom);
    checks++;
    if (instr_valid !== 1'b1 || instr !== d || imem_req !== 1'b0 || pc !== exp_pc) begin
      errors++;
      $display("FAIL decode vld=%b instr=%h req=%b pc=%h required 1 %h 0 %h",
               instr_valid, instr, imem_req, pc, d, exp_pc);
    end
    cyc();
    checks++;
    if (instr_valid !== 1'b0 || instr !== d || imem_req !== 1'b0 || pc !== exp_pc) begin
      errors++;
      $display("FAIL exec_entry vld=%b instr=%h req=%b pc=%h required 0 %h 0 %h",
               instr_valid, instr, imem_req, pc, d, exp_pc);
    end
    for (int unsigned i = 0; i < es; i++) begin
      branch_taken  = 1'($urandom);
      branch_target = $urandom;
      cyc();
      checks++;
      if (instr !== d || pc !== exp_pc || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL exec_hold instr=%h pc=%h req=%b vld=%b required %h %h 0 0",
                 instr, pc, imem_req, instr_valid, d, exp_pc);
      end
    end
    exec_done     = done;
    illegal       = ill;
    branch_taken  = br;
    branch_target = tgt;
    cyc();
    exec_done     = 1'b0;
    illegal       = 1'b0;
    branch_taken  = 1'b0;
`ifdef FETCH_HALT_ON_ILLEGAL_EN
    if (ill) begin
      checks++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== exp_pc) begin
        errors++;
        $display("FAIL halt_entry halt=%b req=%b pc=%h required 1 0 %h", halted, imem_req, pc, exp_pc);
      end
      return;
    end
`endif
    if (ill)     exp_pc = exp_pc + 32'd2;
    else if (br) exp_pc = tgt & 32'hFFFF_FFFE;
    else         exp_pc = exp_pc + 32'd2;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== exp_pc || halted !== 1'b0) begin
      errors++;
      $display("FAIL next_fetch req=%b addr=%h halt=%b required 1 %h 0",
               imem_req, imem_addr, halted, exp_pc);
    end
  endtask

  task automatic test_basic();
    do_instr(16'h1888, 0, 0, 1'b1, 1'b0, 32'h0, 1'b0);
    checks++;
    if (pc !== 32'h2) begin
      errors++;
      $display("FAIL basic_pc pc=%h required 00000002", pc);
    end
  endtask

  task automatic test_wait_states();
    do_instr(16'h2A5C, 3, 0, 1'b1, 1'b0, 32'h0, 1'b0);
    do_instr(16'h7001, 1, 2, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_branch();
    do_instr(16'hD001, 0, 0, 1'b1, 1'b1, 32'h0000_0011, 1'b0);
    do_instr(16'hE7FE, 0, 1, 1'b1, 1'b1, 32'h0000_0101, 1'b0);
    checks++;
    if (imem_addr !== 32'h0000_0100) begin
      errors++;
      $display("FAIL branch_clear_bit0 addr=%h required 00000100", imem_addr);
    end
  endtask

  task automatic test_wrap();
    do_instr(16'h4770, 0, 0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    do_instr(16'hBF00, 2, 0, 1'b1, 1'b0, 32'h0, 1'b0);
    checks++;
    if (imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL pc_wrap addr=%h required 00000000", imem_addr);
    end
  endtask

  task automatic test_random();
    logic ill;
    for (int i = 0; i < 60; i++) begin
`ifdef FETCH_HALT_ON_ILLEGAL_EN
      ill = 1'b0;
`else
      ill = ($urandom_range(0, 7) == 0);
`endif
      do_instr(16'($urandom), $urandom_range(0, 3), $urandom_range(0, 2),
               ill ? 1'($urandom) : 1'b1, ($urandom_range(0, 3) == 0), $urandom, ill);
    end
  endtask

  task automatic test_illegal();
    do_instr(16'hABCD, 0, 0, 1'b1, 1'b1, 32'h0000_0020, 1'b0);
    do_instr(16'hDEFF, 0, 0, 1'b1, 1'b1, 32'h0000_0500, 1'b1);
`ifdef FETCH_HALT_ON_ILLEGAL_EN
    for (int i = 0; i < 6; i++) begin
      imem_ack  = 1'($urandom);
      exec_done = 1'($urandom);
      cyc();
      checks++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h20 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL halt_terminal halt=%b req=%b pc=%h vld=%b required 1 0 00000020 0",
                 halted, imem_req, pc, instr_valid);
      end
    end
    imem_ack  = 1'b0;
    exec_done = 1'b0;
`else
    checks++;
    if (imem_addr !== 32'h22 || halted !== 1'b0) begin
      errors++;
      $display("FAIL illegal_skip addr=%h halt=%b required 00000022 0", imem_addr, halted);
    end
`endif
  endtask

  task automatic test_reset_midfetch();
    test_reset();
    do_instr(16'h4321, 0, 0, 1'b1, 1'b0, 32'h0, 1'b0);
    imem_ack  = 1'b1;
    imem_data = 16'hBEEF;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || instr !== 16'h0 || pc !== RST_PC || halted !== 1'b0 ||
        instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async req=%b instr=%h pc=%h halt=%b vld=%b required 0 0000 %h 0 0",
               imem_req, instr, pc, halted, instr_valid, RST_PC);
    end
    cyc();
    checks++;
    if (instr !== 16'h0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_ignores_ack instr=%h req=%b required 0000 0", instr, imem_req);
    end
    imem_ack = 1'b0;
    rst      = 1'b0;
    exp_pc   = RST_PC;
    cyc();
    do_instr(16'h1C08, 0, 0, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    exp_pc        = RST_PC;
    rst           = 1'b0;
    imem_ack      = 1'b0;
    imem_data     = 16'h0;
    illegal       = 1'b0;
    exec_done     = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    test_reset();
    test_basic();
    test_wait_states();
    test_branch();
    test_wrap();
    test_random();
    test_illegal();
    test_reset_midfetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
